// File: rtl/seq_101_detector_dual_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared types for the dual 1-0-1 detector: Mealy and Moore state encodings
// (binary, 2 bits each) and the pattern being recognised.
// No ports.
// ---------------------------------------------------------------------------
package seq_det_pkg;

  // Bit pattern recognised, oldest bit first.
  localparam logic [2:0] PATTERN = 3'b101;

  // Encoding 2'b11 is unreachable in the Mealy machine and recovers to idle.
  typedef enum logic [1:0] {
    MEALY_IDLE  = 2'b00,
    MEALY_GOT1  = 2'b01,
    MEALY_GOT10 = 2'b10
  } mealy_state_t;

  typedef enum logic [1:0] {
    MOORE_IDLE  = 2'b00,
    MOORE_GOT1  = 2'b01,
    MOORE_GOT10 = 2'b10,
    MOORE_FOUND = 2'b11
  } moore_state_t;

endpackage

// File: rtl/seq_101_detector_dual_if.sv
// ---------------------------------------------------------------------------
// seq_101_detector_dual_if
// Serial data bit and the two detect flags of the dual 1-0-1 detector.
//   x       : serial data bit (master -> slave)
//   y_mealy : Mealy detect flag (slave -> master)
//   y_moore : Moore detect flag (slave -> master)
// The master drives the stream; the detector is the slave.
// ---------------------------------------------------------------------------
interface seq_101_detector_dual_if;
  logic x;
  logic y_mealy;
  logic y_moore;

  modport master (output x, input y_mealy, input y_moore);
  modport slave  (input x, output y_mealy, output y_moore);
endinterface

// File: rtl/seq_101_detector_dual.sv
// ---------------------------------------------------------------------------
// seq_101_detector_dual
// Two independent 1-0-1 detectors running on the same serial input: a Mealy
// machine (flag combinational from state and x) and a Moore machine (flag
// decoded from registered state, one cycle later and glitch-free).
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high; forces both FSMs to idle
//   bus   : slave modport (x in, y_mealy / y_moore out)
// Parameter OVERLAP: 1 = the final '1' of a match may start the next one,
//                    0 = search restarts from idle after each match.
//
// Mealy states
//   state | meaning
//   IDLE  | nothing useful seen
//   GOT1  | last bit was 1
//   GOT10 | last two bits were 1,0; x=1 now completes a match
// Moore states
//   state | meaning
//   IDLE  | nothing useful seen
//   GOT1  | last bit was 1
//   GOT10 | last two bits were 1,0
//   FOUND | 1,0,1 just seen; y_moore high
// ---------------------------------------------------------------------------
module seq_101_detector_dual
  import seq_det_pkg::*;
#(
  parameter int OVERLAP = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  seq_101_detector_dual_if.slave   bus
);

  mealy_state_t r_mealy_state;
  mealy_state_t w_mealy_next;
  moore_state_t r_moore_state;
  moore_state_t w_moore_next;
  logic         w_y_mealy;
  logic         w_y_moore;

  // ---------------- Mealy FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_mealy_state <= MEALY_IDLE;
    else       r_mealy_state <= w_mealy_next;
  end

  always_comb begin
    w_mealy_next = MEALY_IDLE;
    case (r_mealy_state)
      MEALY_IDLE:  w_mealy_next = bus.x ? MEALY_GOT1 : MEALY_IDLE;
      MEALY_GOT1:  w_mealy_next = bus.x ? MEALY_GOT1 : MEALY_GOT10;
      MEALY_GOT10: w_mealy_next = (bus.x && (OVERLAP != 0)) ? MEALY_GOT1 : MEALY_IDLE;
      default:     w_mealy_next = MEALY_IDLE;
    endcase
  end

  always_comb begin
    w_y_mealy = (r_mealy_state == MEALY_GOT10) && bus.x;
  end

  // ---------------- Moore FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_moore_state <= MOORE_IDLE;
    else       r_moore_state <= w_moore_next;
  end

  always_comb begin
    w_moore_next = MOORE_IDLE;
    case (r_moore_state)
      MOORE_IDLE:  w_moore_next = bus.x ? MOORE_GOT1 : MOORE_IDLE;
      MOORE_GOT1:  w_moore_next = bus.x ? MOORE_GOT1 : MOORE_GOT10;
      MOORE_GOT10: w_moore_next = bus.x ? MOORE_FOUND : MOORE_IDLE;
      // With overlap, the '1' that completed the match plus a new '0' is
      // already a valid 1,0 prefix.
      MOORE_FOUND: begin
        if (bus.x)              w_moore_next = MOORE_GOT1;
        else if (OVERLAP != 0)  w_moore_next = MOORE_GOT10;
        else                    w_moore_next = MOORE_IDLE;
      end
      default:     w_moore_next = MOORE_IDLE;
    endcase
  end

  always_comb begin
    w_y_moore = (r_moore_state == MOORE_FOUND);
  end

  assign bus.y_mealy = w_y_mealy;
  assign bus.y_moore = w_y_moore;

  // A match needs three bits, so neither flag can be high two cycles running.
  a_moore_single: assert property (@(posedge clk) disable iff (reset)
                                   w_y_moore |=> !w_y_moore);

endmodule

// File: tb/tb_seq_101_detector_dual.sv
// ---------------------------------------------------------------------------
// tb_seq_101_detector_dual
// Directed bench for the dual 1-0-1 detector. One instance with OVERLAP=1
// and one with OVERLAP=0 share the same serial stream. Each bit is driven
// 1 ns after a rising edge and flags are sampled 4 ns after that edge.
// ---------------------------------------------------------------------------
module tb_seq_101_detector_dual;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic x     = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  seq_101_detector_dual_if if_ov1 ();
  seq_101_detector_dual_if if_ov0 ();

  assign if_ov1.x = x;
  assign if_ov0.x = x;

  seq_101_detector_dual #(.OVERLAP(1)) u_dut_ov1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if_ov1.slave)
  );

  seq_101_detector_dual #(.OVERLAP(0)) u_dut_ov0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if_ov0.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic chk4(input string tag, input logic em1, input logic eo1,
                      input logic em0, input logic eo0);
    chk($sformatf("%s mealy_ov1", tag), if_ov1.y_mealy, em1);
    chk($sformatf("%s moore_ov1", tag), if_ov1.y_moore, eo1);
    chk($sformatf("%s mealy_ov0", tag), if_ov0.y_mealy, em0);
    chk($sformatf("%s moore_ov0", tag), if_ov0.y_moore, eo0);
  endtask

  // Previous bit is consumed by the edge; new bit applied, flags checked.
  task automatic apply(input string tag, input logic b, input logic em1,
                       input logic eo1, input logic em0, input logic eo0);
    @(posedge clk);
    #1 x = b;
    #3 chk4(tag, em1, eo1, em0, eo0);
  endtask

  logic [15:0] stream;
  logic [15:0] m1_mask;
  logic [15:0] o1_mask;
  logic [15:0] m0_mask;
  logic [15:0] o0_mask;
  logic [6:0]  run_bits;
  logic [6:0]  run_m;
  logic [6:0]  run_o;

  initial begin
    // bit i of each vector corresponds to stream bit index i
    stream   = 16'b0010_1010_0110_1100;
    m1_mask  = 16'h2820;   // bits 5, 11, 13
    o1_mask  = 16'h5040;   // bits 6, 12, 14
    m0_mask  = 16'h0820;   // bits 5, 11
    o0_mask  = 16'h1040;   // bits 6, 12
    run_bits = 7'b0101111; // 1,1,1,1,0,1,0
    run_m    = 7'b0100000;
    run_o    = 7'b1000000;

    // Reset held with x toggling: both flags stay low.
    #1 reset = 1'b1;
    #1 chk4("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 x = ~x;
      #2 chk4($sformatf("rst_hold%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    @(posedge clk);
    #2 x = 1'b0;
    reset = 1'b0;

    // Main stream.
    for (int i = 0; i < 16; i++)
      apply($sformatf("stream%0d", i), stream[i], m1_mask[i], o1_mask[i],
            m0_mask[i], o0_mask[i]);
    apply("stream_tail", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Run of ones, then 0,1: single match, Moore one cycle behind Mealy.
    for (int i = 0; i < 7; i++)
      apply($sformatf("run%0d", i), run_bits[i], run_m[i], run_o[i],
            run_m[i], run_o[i]);

    // Mid-operation asynchronous reset while in GOT10 with x=1.
    apply("mrst_sep", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply("mrst_1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply("mrst_0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 x = 1'b1;
    #1 chk4("mrst_pre", 1'b1, 1'b0, 1'b1, 1'b0);
    #1 reset = 1'b1;
    #1 chk4("mrst_async", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 x = ~x;
      #2 chk4($sformatf("mrst_hold%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    @(posedge clk);
    #2 x = 1'b0;
    reset = 1'b0;
    apply("post_1",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply("post_10", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply("post_101", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    apply("post_moore", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Mid-cycle x change while in GOT10.
    apply("mid_sep", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply("mid_1",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply("mid_0",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 x = 1'b0;
    #1 chk4("mid_early", 1'b0, 1'b0, 1'b0, 1'b0);
    #6 x = 1'b1;
    #1 chk4("mid_late", 1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1 chk4("mid_edge", 1'b0, 1'b1, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
